// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the pipelined dual-port RAM.
package dp_ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } collision_mode_e;

  localparam int MAX_RD_LATENCY = 2;

  // One byte lane of a byte-enable merge; callers apply it per lane.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       byte_en);
    return byte_en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dp_ram_pipe_if.sv
// Write/read request bus plus status/result outputs of dp_ram_pipe.
interface dp_ram_pipe_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0]   data_in;
  logic [ADDR_WIDTH-1:0]   write_address;
  logic                    write_enable;
  logic [DATA_WIDTH/8-1:0] write_byte_en;
  logic [ADDR_WIDTH-1:0]   read_address;
  logic                    read_enable;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    rd_valid;
  logic                    rd_oob;
  logic                    wr_oob;
  logic                    collision;
  logic [CNT_WIDTH-1:0]    wr_count;
  logic [CNT_WIDTH-1:0]    rd_count;

  modport master (
    output data_in, write_address, write_enable, write_byte_en, read_address, read_enable,
    input  data_out, rd_valid, rd_oob, wr_oob, collision, wr_count, rd_count
  );

  modport slave (
    input  data_in, write_address, write_enable, write_byte_en, read_address, read_enable,
    output data_out, rd_valid, rd_oob, wr_oob, collision, wr_count, rd_count
  );
endinterface

// File: rtl/dp_ram_array.sv
// Bare storage: byte-enable write port, single-cycle registered read port, no reset.
module dp_ram_array #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH/8-1:0] wbe_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the pre-write word, so same-address accesses are read-first here.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dp_ram_pipe.sv
// Dual-port RAM with read pipeline, collision policy, range checks and saturating counters.
module dp_ram_pipe
  import dp_ram_pkg::*;
#(
  parameter int              DATA_WIDTH     = 64,
  parameter int              ADDR_WIDTH     = 12,
  parameter int              DEPTH          = 4096,
  parameter int              RD_LATENCY     = 1,
  parameter collision_mode_e COLLISION_MODE = READ_FIRST,
  parameter int              CNT_WIDTH      = 16
) (
  input logic          clk,
  input logic          rst,
  dp_ram_pipe_if.slave bus
);
  localparam int                  NB      = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  logic wr_inr, rd_inr, wr_acc, rd_acc, coll_hit;

  assign wr_inr   = {1'b0, bus.write_address} < DEPTH_L;
  assign rd_inr   = {1'b0, bus.read_address} < DEPTH_L;
  assign wr_acc   = bus.write_enable & wr_inr & ~rst;
  assign rd_acc   = bus.read_enable & ~rst;
  assign coll_hit = bus.write_enable & bus.read_enable & wr_inr &
                    (bus.write_address == bus.read_address);

  logic [DATA_WIDTH-1:0] ram_rdata;

  dp_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (bus.write_address),
    .wbe_i   (bus.write_byte_en),
    .wdata_i (bus.data_in),
    .re_i    (rd_acc & rd_inr),
    .raddr_i (bus.read_address),
    .rdata_o (ram_rdata)
  );

  // Write data captured alongside the array read so a write-first hit can be merged.
  logic                  byp_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         wbe_q;

  always_ff @(posedge clk) begin
    if (rst) byp_q <= 1'b0;
    else     byp_q <= (COLLISION_MODE == WRITE_FIRST) && coll_hit;
  end

  always_ff @(posedge clk) begin
    wdata_q <= bus.data_in;
    wbe_q   <= bus.write_byte_en;
  end

  logic [RD_LATENCY:0] vld_pipe_q, oob_pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      oob_pipe_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[RD_LATENCY-1:0], rd_acc};
      oob_pipe_q <= {oob_pipe_q[RD_LATENCY-1:0], rd_acc & ~rd_inr};
    end
  end

  logic [DATA_WIDTH-1:0] res0;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign res0[b*8 +: 8] = oob_pipe_q[0] ? 8'h00 :
                            byp_q ? byte_merge(ram_rdata[b*8 +: 8], wdata_q[b*8 +: 8], wbe_q[b]) :
                                    ram_rdata[b*8 +: 8];
  end

  // Each data stage only loads when its predecessor is valid, so data_out holds between reads.
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] data_pipe_q, data_pipe_d;

  always_comb begin
    data_pipe_d = data_pipe_q;
    if (vld_pipe_q[0]) data_pipe_d[1] = res0;
    for (int k = 2; k <= RD_LATENCY; k++) begin
      if (vld_pipe_q[k-1]) data_pipe_d[k] = data_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) data_pipe_q <= '0;
    else     data_pipe_q <= data_pipe_d;
  end

  logic                 wr_oob_q, coll_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  assign wr_cnt_d = (wr_acc && (wr_cnt_q != '1)) ? wr_cnt_q + CNT_WIDTH'(1) : wr_cnt_q;
  assign rd_cnt_d = (rd_acc && (rd_cnt_q != '1)) ? rd_cnt_q + CNT_WIDTH'(1) : rd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_oob_q <= 1'b0;
      coll_q   <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_oob_q <= bus.write_enable & ~wr_inr;
      coll_q   <= coll_hit;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign bus.data_out  = data_pipe_q[RD_LATENCY];
  assign bus.rd_valid  = vld_pipe_q[RD_LATENCY];
  assign bus.rd_oob    = oob_pipe_q[RD_LATENCY];
  assign bus.wr_oob    = wr_oob_q;
  assign bus.collision = coll_q;
  assign bus.wr_count  = wr_cnt_q;
  assign bus.rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Two configurations driven in lockstep and checked every cycle against a timing-wheel model.
module tb_dp_ram_pipe;
  import dp_ram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0, re = 1'b0;
  logic [11:0] wa = '0, ra = '0;
  logic [63:0] wd = '0;
  logic [7:0]  wbe = '0;

  always #5 clk = ~clk;

  dp_ram_pipe_if #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .CNT_WIDTH(4))  bus0 ();
  dp_ram_pipe_if #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .CNT_WIDTH(16)) bus1 ();

  assign bus0.data_in = wd;  assign bus0.write_address = wa; assign bus0.write_enable = we;
  assign bus0.write_byte_en = wbe; assign bus0.read_address = ra; assign bus0.read_enable = re;
  assign bus1.data_in = wd;  assign bus1.write_address = wa; assign bus1.write_enable = we;
  assign bus1.write_byte_en = wbe; assign bus1.read_address = ra; assign bus1.read_enable = re;

  dp_ram_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(3000), .RD_LATENCY(1),
                .COLLISION_MODE(READ_FIRST), .CNT_WIDTH(4))
    u0 (.clk(clk), .rst(rst), .bus(bus0));
  dp_ram_pipe #(.DATA_WIDTH(64), .ADDR_WIDTH(12), .DEPTH(4096), .RD_LATENCY(2),
                .COLLISION_MODE(WRITE_FIRST), .CNT_WIDTH(16))
    u1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference model state, per instance
  int          DEP  [2] = '{3000, 4096};
  int          LAT  [2] = '{1, 2};
  bit          WF   [2] = '{1'b0, 1'b1};
  int          CMAX [2] = '{15, 65535};
  logic [63:0] mem  [2][4096];
  int          wc [2], rc [2];
  logic [63:0] last [2];
  bit          woob_e [2], coll_e [2];
  bit          sv [2][8];
  logic [63:0] sd [2][8];
  bit          so [2][8];
  int          t = 0;

  int checks = 0, errors = 0;

  // capture helpers for directed sequences
  bit          cap_v [2];
  logic [63:0] cap_d [2];
  bit          cap_o [2];
  bit          st_on = 1'b0;
  int          st_n = 0, st_first = -1, st_last = -1;
  logic [63:0] st_d [16];

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n,
                                        input logic [7:0] be);
    logic [63:0] r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input int i, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s u%0d got %h expected %h (t=%0d)", nm, i, a, e, t);
    end
  endtask

  task automatic model_edge();
    t++;
    for (int i = 0; i < 2; i++) begin
      bit win, rin;
      logic [63:0] v;
      if (rst) begin
        wc[i] = 0; rc[i] = 0; last[i] = '0; woob_e[i] = 0; coll_e[i] = 0;
        for (int s = 0; s < 8; s++) sv[i][s] = 0;
      end else begin
        win = int'(wa) < DEP[i];
        rin = int'(ra) < DEP[i];
        woob_e[i] = we && !win;
        coll_e[i] = we && re && win && (wa == ra);
        if (re) begin
          if (rc[i] < CMAX[i]) rc[i]++;
          v = rin ? mem[i][ra] : 64'h0;
          if (coll_e[i] && WF[i]) v = merge(v, wd, wbe);
          sv[i][(t + LAT[i]) % 8] = 1;
          sd[i][(t + LAT[i]) % 8] = v;
          so[i][(t + LAT[i]) % 8] = !rin;
        end
        if (we && win) begin
          mem[i][wa] = merge(mem[i][wa], wd, wbe);
          if (wc[i] < CMAX[i]) wc[i]++;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      bit ev, eo;
      logic [63:0] a_d;
      logic a_v, a_o, a_wo, a_c;
      logic [15:0] a_wc, a_rc;
      ev = sv[i][t % 8];
      if (ev) last[i] = sd[i][t % 8];
      eo = ev && so[i][t % 8];
      sv[i][t % 8] = 0;
      if (i == 0) begin
        a_d = bus0.data_out; a_v = bus0.rd_valid; a_o = bus0.rd_oob; a_wo = bus0.wr_oob;
        a_c = bus0.collision; a_wc = 16'(bus0.wr_count); a_rc = 16'(bus0.rd_count);
      end else begin
        a_d = bus1.data_out; a_v = bus1.rd_valid; a_o = bus1.rd_oob; a_wo = bus1.wr_oob;
        a_c = bus1.collision; a_wc = bus1.wr_count; a_rc = bus1.rd_count;
      end
      chk("rd_valid",  i, 64'(a_v),  64'(ev));
      chk("data_out",  i, a_d,       last[i]);
      chk("rd_oob",    i, 64'(a_o),  64'(eo));
      chk("wr_oob",    i, 64'(a_wo), 64'(woob_e[i]));
      chk("collision", i, 64'(a_c),  64'(coll_e[i]));
      chk("wr_count",  i, 64'(a_wc), 64'(wc[i]));
      chk("rd_count",  i, 64'(a_rc), 64'(rc[i]));
      if (a_v === 1'b1) begin
        cap_v[i] = 1; cap_d[i] = a_d; cap_o[i] = a_o;
        if (st_on && i == 1) begin
          if (st_n < 16) st_d[st_n] = a_d;
          if (st_first < 0) st_first = t;
          st_last = t;
          st_n++;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 2))
      0:       return 12'($urandom_range(0, 31));
      1:       return 12'($urandom_range(2990, 3010));
      default: return 12'($urandom_range(4088, 4095));
    endcase
  endfunction

  typedef struct {
    bit          we;
    logic [11:0] wa;
    logic [63:0] wd;
    logic [7:0]  wbe;
    bit          re;
    logic [11:0] ra;
    logic [63:0] e0, e1;
    bit          o0, o1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{1, 12'h010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[1]  = '{0, 12'h000, 64'h0, 8'h00, 1, 12'h010,
                64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 0, 0};
    tbl[2]  = '{1, 12'h020, 64'h0, 8'hFF, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[3]  = '{1, 12'h020, 64'hFFFF_FFFF_FFFF_FFFF, 8'h05, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[4]  = '{0, 12'h000, 64'h0, 8'h00, 1, 12'h020, 64'h00FF_00FF, 64'h00FF_00FF, 0, 0};
    tbl[5]  = '{1, 12'h005, 64'h1111, 8'hFF, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[6]  = '{1, 12'h005, 64'h2222, 8'hFF, 1, 12'h005, 64'h1111, 64'h2222, 0, 0};
    tbl[7]  = '{0, 12'h000, 64'h0, 8'h00, 1, 12'h005, 64'h2222, 64'h2222, 0, 0};
    tbl[8]  = '{1, 12'hBB8, 64'hABCD, 8'hFF, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[9]  = '{0, 12'h000, 64'h0, 8'h00, 1, 12'hBB8, 64'h0, 64'hABCD, 1, 0};
    tbl[10] = '{1, 12'h006, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 0, 12'h000, 64'h0, 64'h0, 0, 0};
    tbl[11] = '{1, 12'h006, 64'h5555_5555_5555_5555, 8'h0F, 1, 12'h006,
                64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_5555_5555, 0, 0};

    rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Directed vectors
    for (int k = 0; k < 12; k++) begin
      we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd; wbe = tbl[k].wbe;
      re = tbl[k].re; ra = tbl[k].ra;
      cap_v[0] = 0; cap_v[1] = 0;
      cyc();
      we = 0; re = 0;
      repeat (3) cyc();
      if (tbl[k].re) begin
        chk("tbl_vld",  0, 64'(cap_v[0]), 64'd1);
        chk("tbl_data", 0, cap_d[0], tbl[k].e0);
        chk("tbl_oob",  0, 64'(cap_o[0]), 64'(tbl[k].o0));
        chk("tbl_vld",  1, 64'(cap_v[1]), 64'd1);
        chk("tbl_data", 1, cap_d[1], tbl[k].e1);
        chk("tbl_oob",  1, 64'(cap_o[1]), 64'(tbl[k].o1));
      end
      if (k == 1) begin
        chk("first_rdcnt", 0, 64'(bus0.rd_count), 64'd1);
        chk("first_wrcnt", 1, 64'(bus1.wr_count), 64'd1);
      end
    end

    // Fill every address the random phase may touch
    for (int a = 0; a < 4096; a++) begin
      if (a < 32 || (a >= 2990 && a <= 3010) || a >= 4088) begin
        we = 1; wa = 12'(a); wd = {$urandom, $urandom}; wbe = 8'hFF;
        cyc();
      end
    end
    we = 0;

    // Streaming 16 back-to-back reads
    st_on = 1'b1;
    for (int a = 0; a < 16; a++) begin
      re = 1; ra = 12'(a);
      cyc();
    end
    re = 0;
    repeat (4) cyc();
    st_on = 1'b0;
    chk("stream_cnt",  1, 64'(st_n), 64'd16);
    chk("stream_span", 1, 64'(st_last - st_first + 1), 64'd16);
    for (int k = 0; k < 16; k++) chk("stream_data", 1, st_d[k], mem[1][k]);

    // Reset with reads in flight
    re = 1; ra = 12'h001; cyc();
    ra = 12'h002; cyc();
    re = 0; rst = 1; cyc();
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("rst_vld",  0, 64'(bus0.rd_valid), 64'd0);
      chk("rst_vld",  1, 64'(bus1.rd_valid), 64'd0);
      chk("rst_data", 1, bus1.data_out, 64'd0);
    end

    // Counter saturation
    for (int k = 0; k < 20; k++) begin
      we = 1; wa = 12'h030; wd = {$urandom, $urandom}; wbe = 8'hFF;
      cyc();
    end
    we = 0;
    cyc();
    chk("sat_wr", 0, 64'(bus0.wr_count), 64'd15);
    chk("sat_wr", 1, 64'(bus1.wr_count), 64'd20);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 1) == 1;
      re  = $urandom_range(0, 1) == 1;
      wa  = pick_addr();
      ra  = ($urandom_range(0, 3) == 0) ? wa : pick_addr();
      wd  = {$urandom, $urandom};
      wbe = 8'($urandom);
      cyc();
    end
    rst = 0; we = 0; re = 0;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dp_ram_pipe.md
# dp_ram_pipe

Parametrised successor to the 64-bit / 4K-entry dual-port RAM. One write port, one read port, per-byte write enables, a configurable read pipeline with a `rd_valid` qualifier, a selectable read-during-write collision policy, out-of-range detection, and saturating access counters. It sits behind the existing RAM bench interface and is a drop-in replacement when the parameters are at their defaults.

## Interface
- `DATA_WIDTH`, 64: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 12: address width in bits.
- `DEPTH`, 4096: number of implemented words, at most 2^ADDR_WIDTH.
- `RD_LATENCY`, 1: cycles from an accepted read to `rd_valid`; legal values are 1 or 2.
- `COLLISION_MODE`, `READ_FIRST`: same-address policy, either `READ_FIRST` or `WRITE_FIRST`.
- `CNT_WIDTH`, 16: width of each access counter.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `data_in`, in, DATA_WIDTH: write data.
- `write_address`, in, ADDR_WIDTH: write address.
- `write_enable`, in, 1: write request.
- `write_byte_en`, in, DATA_WIDTH/8: per-byte lane enables.
- `read_address`, in, ADDR_WIDTH: read address.
- `read_enable`, in, 1: read request.
- `data_out`, out, DATA_WIDTH: read data, qualified by `rd_valid`.
- `rd_valid`, out, 1: `data_out` holds the result of a read.
- `rd_oob`, out, 1: the result on `data_out` came from an out-of-range read; aligned with `rd_valid`.
- `wr_oob`, out, 1: one-cycle pulse one cycle after an out-of-range write request.
- `collision`, out, 1: one-cycle pulse one cycle after a same-cycle, same-address read and write.
- `wr_count`, out, CNT_WIDTH: number of in-range writes committed.
- `rd_count`, out, CNT_WIDTH: number of reads accepted.

## Operation
- Write: on a rising `clk` with `write_enable` high and `write_address < DEPTH`, the RAM stores `data_in` byte lane i if and only if `write_byte_en[i]`.
  - An all-zero `write_byte_en` leaves the RAM unchanged but still increments `wr_count`.
- Out-of-range write: `write_address >= DEPTH` has no RAM effect and no count; `wr_oob` pulses.
- Read: `read_enable` high is accepted every cycle, with no backpressure; `rd_count` increments.
  - In-range: `data_out` is the stored word after RD_LATENCY cycles.
  - Out-of-range: `data_out` is 0 and `rd_oob` is 1, after the same latency.
- Collision: same cycle, both enables high, equal in-range addresses.
  - `READ_FIRST`: the read returns the old word.
  - `WRITE_FIRST`: the read returns the new word, merged per byte. Enabled lanes come from `data_in`; the other lanes come from the old word.
  - `collision` pulses in both modes.
- Counters saturate at 2^CNT_WIDTH−1; they do not wrap.
- When `rd_valid` is 0, `data_out` holds its last valid value; it is not zeroed.
- RAM contents are not affected by reset and are X until written. The bench must write before reading.

## Timing
- Reset values: `data_out` = 0, `rd_valid` = 0, `rd_oob` = 0, `wr_oob` = 0, `collision` = 0, `wr_count` = 0, `rd_count` = 0.
- Reset also clears every read-pipeline valid stage.
- Reset has priority. In a cycle with `rst` high:
  - No write commits.
  - No read is accepted.
  - In-flight reads are discarded, so no `rd_valid` appears after reset deasserts.
- Read latency:
  - RD_LATENCY = 1: `read_enable` at edge N gives `rd_valid` and `data_out` after edge N+1.
  - RD_LATENCY = 2: adds one output register stage, so results appear after edge N+2.
- Back-to-back reads give back-to-back `rd_valid` with results in order. Throughput is one read per cycle.
- A write at edge N is visible to a read sampled at edge N+1 or later, regardless of mode.
- `wr_oob` and `collision` are registered and appear in the cycle after the request edge.

## Structure
- Package `dp_ram_pkg`:
  - `collision_mode_e` enum with values `READ_FIRST` and `WRITE_FIRST`.
  - `byte_merge` function taking (old, new, byte_en).
  - Constant for the maximum RD_LATENCY.
- Sub-module `dp_ram_array`: bare storage with a byte-enable write port and a single-cycle registered read port; no reset.
- Top level holds:
  - collision compare and bypass mux;
  - out-of-range compare;
  - latency pipeline;
  - counters.

## Test plan
- Write 64'hDEAD_BEEF_0123_4567 to address 0x010 with all byte enables, then read 0x010 → `rd_valid` after RD_LATENCY cycles with the same data, `rd_count` = 1, `wr_count` = 1.
- Byte-lane write: address 0x020 holds 64'h0, then write 64'hFFFF_FFFF_FFFF_FFFF with `write_byte_en` = 8'b0000_0101 → read returns 64'h0000_0000_00FF_00FF.
- Collision at address 0x005:
  - Setup: old word 64'h1111, new word 64'h2222, all byte enables.
  - `READ_FIRST` returns 64'h1111; `WRITE_FIRST` returns 64'h2222.
  - `collision` pulses once in both modes.
- With DEPTH = 3000:
  - Write to 0xBB8 → `wr_oob` pulses, `wr_count` unchanged.
  - Read 0xBB8 → `data_out` = 0 with `rd_oob` = 1.
- Streaming: reads to 0x000–0x00F on 16 consecutive cycles with RD_LATENCY = 2 → 16 consecutive `rd_valid` cycles, data in address order.
- Reset and saturation:
  - Assert `rst` with two reads in flight → no `rd_valid` after release, all outputs 0.
  - Separately, with CNT_WIDTH = 4, perform 20 writes → `wr_count` stays at 15.
